// File: rtl/xbar_master_port.sv
// ---------------------------------------------------------------------------
// xbar_master_port
//
// Per-master front end placed directly upstream of a crossbar master port.
// Core commands are buffered in a DEPTH-entry FIFO. They are issued one at a
// time on the crossbar req/ack handshake, and exactly one response is returned
// per command.
//
// Handshakes:
//   cmd : a command transfers on a rising edge where cmd_valid && cmd_ready.
//         cmd_ready depends only on registered state.
//   rsp : a response transfers on a rising edge where rsp_valid && rsp_ready.
//         rsp_valid and the rsp_* fields stay stable until that edge.
//   xbar: master_req and the master_* fields stay stable until master_ack is
//         sampled high, or until the timeout expires. master_rdata is sampled
//         on the edge that follows the ack edge.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata  command interface from the core
//   rsp_valid/ready/write/err/rdata   response interface to the core
//   master_req/cmd/addr/wdata         request towards the crossbar
//   master_ack/rdata                  acknowledge and read data from the crossbar
//   fifo_level                      current FIFO occupancy
//   busy                            FSM active or FIFO non-empty
//   dbg_state_o                     FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module xbar_master_port #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [31:0]              cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic                     rsp_err,
  output logic [31:0]              rsp_rdata,
  output logic                     master_req,
  output logic                     master_cmd,
  output logic [31:0]              master_addr,
  output logic [31:0]              master_wdata,
  input  logic                     master_ack,
  input  logic [31:0]              master_rdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // The counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // FIFO storage. An entry is {write, addr, wdata}.
  logic [64:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [64:0]   head;

  // FSM and output registers.
  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          mcmd_q, mcmd_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rsp_write_q, rsp_write_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready = (count_q != FULL);
  assign push      = cmd_valid && cmd_ready;
  // Only an idle FSM drains the FIFO, so each entry is issued exactly once.
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // No reset on the storage: entries are never read unless count_q shows them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mcmd_d      = mcmd_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    to_cnt_d    = to_cnt_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      // Passing through IDLE keeps master_req low for at least one cycle
      // between transactions, so the crossbar re-arbitrates from idle.
      S_IDLE: begin
        if (count_q != '0) begin
          {mcmd_d, maddr_d, mwdata_d} = head;
          req_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // Ack takes priority over a timeout that expires in the same cycle.
        if (master_ack) begin
          req_d = 1'b0;
          if (mcmd_q) begin
            rsp_write_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else begin
            state_d = S_RDATA;
          end
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          req_d       = 1'b0;
          rsp_write_d = mcmd_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      // Read data is valid on the cycle after the ack.
      S_RDATA: begin
        rsp_rdata_d = master_rdata;
        rsp_err_d   = 1'b0;
        rsp_write_d = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      mcmd_q      <= 1'b0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      to_cnt_q    <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mcmd_q      <= mcmd_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      to_cnt_q    <= to_cnt_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_write    = rsp_write_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign master_req   = req_q;
  assign master_cmd   = mcmd_q;
  assign master_addr  = maddr_q;
  assign master_wdata = mwdata_q;
  assign fifo_level   = count_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_xbar_master_port.sv
// ---------------------------------------------------------------------------
// tb_xbar_master_port
//
// Each command carries a plan for how the simulated crossbar will treat it:
//   delay - number of request cycles before the ack is sampled;
//           a delay above TIMEOUT means the ack never comes.
//   rdata - the read data the crossbar returns.
// When a command is accepted, the bench pushes its expected response into
// exp_q. The crossbar process checks each request against its plan. The
// monitor process pops exp_q and compares whenever a response is accepted.
// ---------------------------------------------------------------------------
module tb_xbar_master_port;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        master_req, master_cmd, master_ack;
  logic [31:0] master_addr, master_wdata, master_rdata;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        busy;
  logic [1:0]  dbg_state;

  xbar_master_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .master_req(master_req), .master_cmd(master_cmd), .master_addr(master_addr),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata),
    .fifo_level(fifo_level), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } txn_t;

  logic [33:0] exp_q[$];    // {write, err, rdata}
  txn_t        plan_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          hold_ready = 0;

  function automatic logic [33:0] model_rsp(input txn_t t);
    if (t.delay > TIMEOUT) return {t.write, 1'b1, 32'h0};
    if (t.write)           return {1'b1, 1'b0, 32'h0};
    return {1'b0, 1'b0, t.rdata};
  endfunction

  function automatic int model_req_cycles(input txn_t t);
    return (t.delay > TIMEOUT) ? TIMEOUT : t.delay;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic push(input txn_t t);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    while (!cmd_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      fail_now("push_blocked");
    end else begin
      // cmd_ready is high now, so the command is taken at the coming edge.
      exp_q.push_back(model_rsp(t));
      plan_q.push_back(t);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int dl, input logic [31:0] rd);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = d; t.delay = dl; t.rdata = rd;
    return t;
  endfunction

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_busy", busy, 0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- crossbar slave model ----------------
  initial begin
    txn_t cur;
    int   cyc = 0;
    bit   in_txn = 0;
    master_ack   = 1'b0;
    master_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn     = 0;
        master_ack = 1'b0;
      end else begin
        master_rdata = $urandom;
        if (in_txn && master_req) begin
          cyc++;
          check("req_stable", {master_cmd, master_addr, master_wdata},
                {cur.write, cur.addr, cur.wdata});
          master_ack = (cyc == cur.delay);
        end else if (in_txn) begin
          in_txn = 0;
          check("req_cycles", cyc, model_req_cycles(cur));
          // Writes and timeouts respond straight away; reads go through a data-capture cycle first.
          check("rsp_latency", rsp_valid, (cur.delay > TIMEOUT) ? 1'b1 : cur.write);
          if (!cur.write && cur.delay <= TIMEOUT) master_rdata = cur.rdata;
          master_ack = 1'($urandom_range(0, 1));
        end else if (master_req) begin
          if (plan_q.size() == 0) begin
            fail_now("req_unexpected");
            cur = mk(1'b0, 32'h0, 32'h0, TIMEOUT + 1, 32'h0);
          end else begin
            cur = plan_q.pop_front();
            check("req_fields", {master_cmd, master_addr, master_wdata},
                  {cur.write, cur.addr, cur.wdata});
          end
          in_txn     = 1;
          cyc        = 1;
          master_ack = (cur.delay == 1);
        end else begin
          // An ack outside a request must be ignored.
          master_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    logic [33:0] held_v, act, e;
    bit held = 0;
    bit r;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      act = {rsp_write, rsp_err, rsp_rdata};
      if (!rst_n) begin
        held      = 0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (held) check("rsp_stable", act, held_v);
        r = !hold_ready && ($urandom_range(0, 3) != 0);
        rsp_ready = r;
        if (r) begin
          held = 0;
          if (exp_q.size() == 0) fail_now("rsp_unexpected");
          else begin
            e = exp_q.pop_front();
            check("rsp", act, e);
          end
        end else begin
          held   = 1;
          held_v = act;
        end
      end else begin
        held      = 0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    txn_t t;
    int   g;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    // State during reset.
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {rsp_valid, rsp_write, rsp_err, rsp_rdata, master_req, master_cmd,
                          master_addr, master_wdata, busy}, '0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, acked on the 4th request cycle, with latency checks.
    push(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 32'h0));
    check("lat_req_e0", master_req, 0);
    @(negedge clk);
    check("lat_req_e1", master_req, 1);
    drain();

    // Single read.
    push(mk(1'b0, 32'h8000_0004, 32'h0, 2, 32'h1234_5678));
    drain();

    // Fill the FIFO while the first entry sits in REQ.
    push(mk(1'b1, 32'h100, 32'h1, 6, 32'h0));
    for (int i = 0; i < 4; i++) begin
      push(mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, TIMEOUT), $urandom));
      if (i == 2) begin
        check("fill_level3", fifo_level, 3);
        check("fill_ready3", cmd_ready, 1);
      end
    end
    check("fill_level4", fifo_level, 4);
    check("fill_ready_full", cmd_ready, 0);
    push(mk(1'b0, 32'h200, 32'h0, 3, 32'hCAFE_F00D));
    drain();

    // Timeouts: no ack at all, and an ack on the expiry cycle.
    push(mk(1'b1, 32'h300, 32'h55, TIMEOUT + 1, 32'h0));
    push(mk(1'b0, 32'h304, 32'h0, TIMEOUT + 2, 32'h0));
    push(mk(1'b0, 32'h308, 32'h0, TIMEOUT, 32'hA5A5_0001));
    push(mk(1'b1, 32'h30C, 32'h66, TIMEOUT, 32'h0));
    drain();

    // Response backpressure.
    hold_ready = 1;
    push(mk(1'b0, 32'h400, 32'h0, 2, 32'hBEEF_0042));
    push(mk(1'b1, 32'h404, 32'h77, 1, 32'h0));
    g = 0;
    while (!rsp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("bp_rsp_seen", rsp_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_req_low", master_req, 0);
      check("bp_level", fifo_level, 1);
    end
    hold_ready = 0;
    drain();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      t = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, TIMEOUT + 2), $urandom);
      push(t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset during REQ with two entries queued.
    for (int i = 0; i < 3; i++) push(mk(1'b1, 32'h500 + i, 32'h0, TIMEOUT + 2, 32'h0));
    check("pre_rst_req", master_req, 1);
    check("pre_rst_level", fifo_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", master_req, 0);
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ready", cmd_ready, 1);
    exp_q.delete();
    plan_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_idle", {busy, master_req, rsp_valid}, 0);
    check("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
